// File: rtl/sparc_windowed_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sparc_windowed_regfile: SPARC V8 windowed integer register file with     |
// | SAVE/RESTORE, WIM-based overflow/underflow traps. Rev 1.0                 |
// +--------------------------------------------------------------------------+
module sparc_windowed_regfile #(
  parameter int DATA_W   = 32,
  parameter int NWINDOWS = 8,
  localparam int CWP_W   = $clog2(NWINDOWS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic                we,
  input  logic [4:0]          rd,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                save,
  input  logic                restore,
  input  logic                cwp_we,
  input  logic [CWP_W-1:0]    cwp_wdata,
  input  logic                wim_we,
  input  logic [NWINDOWS-1:0] wim_wdata,
  output logic [DATA_W-1:0]   val1,
  output logic [DATA_W-1:0]   val2,
  output logic [CWP_W-1:0]    cwp,
  output logic [NWINDOWS-1:0] wim,
  output logic                win_ovf,
  output logic                win_unf
);

  localparam int NPHYS  = 8 + 16 * NWINDOWS;
  localparam int PHYS_W = $clog2(NPHYS);

  localparam logic [PHYS_W:0]  c_winregs  = (PHYS_W+1)'(16 * NWINDOWS);
  localparam logic [PHYS_W:0]  c_globals  = (PHYS_W+1)'(8);
  localparam logic [CWP_W:0]   c_nwin     = (CWP_W+1)'(NWINDOWS);
  localparam logic [CWP_W-1:0] c_cwp_max  = CWP_W'(NWINDOWS - 1);

  logic [DATA_W-1:0] r_regs [NPHYS];

  // Windowed offset never exceeds twice the window space, so one conditional
  // subtraction implements the modulo for any NWINDOWS.
  function automatic logic [PHYS_W-1:0] phys(input logic [4:0] r, input logic [CWP_W-1:0] c);
    logic [PHYS_W:0] off;
    if (r < 5'd8) begin
      phys = PHYS_W'(r);
    end else begin
      off = (PHYS_W+1)'({c, 4'b0000}) + (PHYS_W+1)'(r - 5'd8);
      if (off >= c_winregs) off = off - c_winregs;
      phys = PHYS_W'(off + c_globals);
    end
  endfunction

  logic [PHYS_W-1:0] w_rs1_idx, w_rs2_idx, w_rd_idx;
  logic              w_wr_en;
  logic [CWP_W-1:0]  w_cwp_dec, w_cwp_inc;
  logic              w_do_save, w_do_restore;

  always_comb begin
    w_rs1_idx    = phys(rs1, cwp);
    w_rs2_idx    = phys(rs2, cwp);
    w_rd_idx     = phys(rd, cwp);
    w_wr_en      = we && (rd != 5'd0);
    w_cwp_dec    = (cwp == '0) ? c_cwp_max : cwp - 1'b1;
    w_cwp_inc    = (cwp == c_cwp_max) ? '0 : cwp + 1'b1;
    w_do_save    = !cwp_we && save && !restore;
    w_do_restore = !cwp_we && restore && !save;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPHYS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_rd_idx] <= wdata;
    end
  end

  // Read ports see the same-cycle write through the bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      val1 <= '0;
      val2 <= '0;
    end else begin
      if (rs1 == 5'd0)                          val1 <= '0;
      else if (w_wr_en && w_rd_idx == w_rs1_idx) val1 <= wdata;
      else                                       val1 <= r_regs[w_rs1_idx];
      if (rs2 == 5'd0)                          val2 <= '0;
      else if (w_wr_en && w_rd_idx == w_rs2_idx) val2 <= wdata;
      else                                       val2 <= r_regs[w_rs2_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cwp     <= '0;
      wim     <= '0;
      win_ovf <= 1'b0;
      win_unf <= 1'b0;
    end else begin
      win_ovf <= w_do_save && wim[w_cwp_dec];
      win_unf <= w_do_restore && wim[w_cwp_inc];
      if (cwp_we) begin
        if ({1'b0, cwp_wdata} < c_nwin) cwp <= cwp_wdata;
      end else if (w_do_save) begin
        if (!wim[w_cwp_dec]) cwp <= w_cwp_dec;
      end else if (w_do_restore) begin
        if (!wim[w_cwp_inc]) cwp <= w_cwp_inc;
      end
      if (wim_we) wim <= wim_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sparc_windowed_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sparc_windowed_regfile: directed + random check of the windowed       |
// | register file against an array/arithmetic reference model. Rev 1.0       |
// +--------------------------------------------------------------------------+
module tb_sparc_windowed_regfile;

  localparam int DW    = 32;
  localparam int NW    = 7;
  localparam int CW    = $clog2(NW);
  localparam int NPHYS = 8 + 16 * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs1, rs2, rd;
  logic          we, save, restore, cwp_we, wim_we;
  logic [DW-1:0] wdata;
  logic [CW-1:0] cwp_wdata;
  logic [NW-1:0] wim_wdata;
  logic [DW-1:0] val1, val2;
  logic [CW-1:0] cwp;
  logic [NW-1:0] wim;
  logic          win_ovf, win_unf;

  sparc_windowed_regfile #(.DATA_W(DW), .NWINDOWS(NW)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .we(we), .rd(rd), .wdata(wdata),
    .save(save), .restore(restore), .cwp_we(cwp_we), .cwp_wdata(cwp_wdata),
    .wim_we(wim_we), .wim_wdata(wim_wdata), .val1(val1), .val2(val2), .cwp(cwp),
    .wim(wim), .win_ovf(win_ovf), .win_unf(win_unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_regs [NPHYS];
  int            m_cwp;
  logic [NW-1:0] m_wim;

  function automatic int map(input int r, input int c);
    if (r < 8) return r;
    return 8 + ((c * 16 + r - 8) % (16 * NW));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    reset = 0; we = 0; save = 0; restore = 0; cwp_we = 0; wim_we = 0;
  endtask

  // One clock: advance the model by the architectural rules, then compare all outputs.
  task automatic cycle();
    logic [DW-1:0] e1, e2;
    logic eo, eu;
    int t;
    eo = 0; eu = 0;
    if (reset) begin
      for (int i = 0; i < NPHYS; i++) m_regs[i] = '0;
      m_cwp = 0; m_wim = '0; e1 = '0; e2 = '0;
    end else begin
      if (we && rd != 0) m_regs[map(rd, m_cwp)] = wdata;
      e1 = (rs1 == 0) ? '0 : m_regs[map(rs1, m_cwp)];
      e2 = (rs2 == 0) ? '0 : m_regs[map(rs2, m_cwp)];
      if (cwp_we) begin
        if (int'(cwp_wdata) < NW) m_cwp = int'(cwp_wdata);
      end else if (save != restore) begin
        t = save ? (m_cwp + NW - 1) % NW : (m_cwp + 1) % NW;
        if (m_wim[t]) begin
          if (save) eo = 1; else eu = 1;
        end else begin
          m_cwp = t;
        end
      end
      if (wim_we) m_wim = wim_wdata;
    end
    @(posedge clk); #1;
    chk("val1", val1, e1);
    chk("val2", val2, e2);
    chk("cwp", cwp, m_cwp);
    chk("wim", wim, m_wim);
    chk("win_ovf", win_ovf, eo);
    chk("win_unf", win_unf, eu);
  endtask

  task automatic set_cwp(input int c);
    clear(); cwp_we = 1; cwp_wdata = CW'(c); cycle(); clear();
  endtask

  task automatic set_wim(input logic [NW-1:0] w);
    clear(); wim_we = 1; wim_wdata = w; cycle(); clear();
  endtask

  initial begin
    clear(); rs1 = 0; rs2 = 0; rd = 0; wdata = '0; cwp_wdata = '0; wim_wdata = '0;
    m_cwp = 0; m_wim = '0;
    for (int i = 0; i < NPHYS; i++) m_regs[i] = '0;

    // Reset, read every architectural register, r0 write dropped
    reset = 1; cycle(); clear();
    chk("rst_cwp", cwp, 0);
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i); cycle();
      chk("rst_read", val1, 0);
    end
    we = 1; rd = 0; wdata = 32'hDEADBEEF; cycle(); clear();
    rs1 = 0; cycle();
    chk("r0_zero", val1, 0);

    // Outs of window 3 become ins of window 2 after SAVE
    set_cwp(3);
    we = 1; rd = 8; wdata = 32'h11111111; cycle(); clear();
    save = 1; cycle(); clear();
    chk("save_cwp", cwp, 2);
    rs1 = 24; rs2 = 8; cycle();
    chk("alias_in", val1, 32'h11111111);
    chk("outs_clean", val2, 0);

    // Globals survive window wrap
    set_cwp(0);
    we = 1; rd = 5; wdata = 32'hA5A5A5A5; cycle(); clear();
    for (int i = 0; i < 3; i++) begin save = 1; cycle(); clear(); end
    chk("wrap_cwp", cwp, NW - 3);
    rs1 = 5; cycle();
    chk("global_r5", val1, 32'hA5A5A5A5);

    // Overflow / underflow traps
    set_wim(7'b0000100);
    set_cwp(3);
    save = 1; cycle(); clear();
    chk("ovf_pulse", win_ovf, 1);
    chk("ovf_cwp", cwp, 3);
    cycle();
    chk("ovf_drop", win_ovf, 0);
    set_cwp(1);
    restore = 1; cycle(); clear();
    chk("unf_pulse", win_unf, 1);
    chk("unf_cwp", cwp, 1);

    // Bypass and simultaneous save+restore
    set_wim('0);
    we = 1; rd = 17; wdata = 32'h12345678; rs1 = 17; cycle(); clear();
    chk("bypass", val1, 32'h12345678);
    save = 1; restore = 1; cycle(); clear();
    chk("sr_cwp", cwp, 1);
    chk("sr_trap", {win_ovf, win_unf}, 0);

    // Out-of-range CWP load, wrap of restore, reset during save
    set_cwp(2);
    cwp_we = 1; cwp_wdata = 3'd7; cycle(); clear();
    chk("cwp_ignore", cwp, 2);
    set_cwp(6);
    restore = 1; cycle(); clear();
    chk("restore_wrap", cwp, 0);
    set_wim(7'b0000100);
    set_cwp(3);
    save = 1; cycle(); clear();
    reset = 1; save = 1; cycle(); clear();
    chk("rst_mid_cwp", cwp, 0);
    chk("rst_mid_trap", win_ovf, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      clear();
      reset     = ($urandom_range(99) == 0);
      rs1       = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
      we        = ($urandom_range(2) != 0);
      wdata     = $urandom;
      save      = ($urandom_range(5) == 0);
      restore   = ($urandom_range(5) == 0);
      cwp_we    = ($urandom_range(11) == 0);
      cwp_wdata = CW'($urandom);
      wim_we    = ($urandom_range(15) == 0);
      wim_wdata = ($urandom_range(1) == 0) ? '0 : NW'(1 << $urandom_range(NW - 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
